// File: rtl/tpu_accum_pkg.sv
// Shared accumulator definitions: FSM states, default widths and vector types
// used by the preload and cast paths.
package tpu_accum_pkg;
  localparam int ACC_ARRAY_SIZE = 64;
  localparam int ACC_WIDE_WIDTH = 128;
  localparam int ACC_IN_WIDTH   = 32;
  localparam int ACC_SHIFT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  typedef logic signed [ACC_WIDE_WIDTH-1:0] acc_word_t;
  typedef acc_word_t [ACC_ARRAY_SIZE-1:0]   acc_vec_t;
endpackage

// File: rtl/tpu_accum_widen.sv
// Combinational widening of one input word: sign-extend to the accumulator
// width, then arithmetic left shift (vacated low bits are zero).
module tpu_accum_widen
  import tpu_accum_pkg::*;
#(
  parameter int IN_WIDTH   = ACC_IN_WIDTH,
  parameter int WIDE_WIDTH = ACC_WIDE_WIDTH,
  parameter int SHIFT_BITS = ACC_SHIFT_BITS
) (
  input  logic signed [IN_WIDTH-1:0]   in_data,
  input  logic        [SHIFT_BITS-1:0] shift,
  output logic signed [WIDE_WIDTH-1:0] wide
);
  logic signed [WIDE_WIDTH-1:0] ext;

  assign ext  = {{(WIDE_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
  assign wide = ext <<< shift;
endmodule

// File: rtl/tpu_accum_preload.sv
// Streams IN_WIDTH words into an ARRAY_SIZE x WIDE_WIDTH accumulator preload
// vector, one column per accepted word, and presents it with valid/ready.
module tpu_accum_preload
  import tpu_accum_pkg::*;
#(
  parameter int ARRAY_SIZE = ACC_ARRAY_SIZE,
  parameter int WIDE_WIDTH = ACC_WIDE_WIDTH,
  parameter int IN_WIDTH   = ACC_IN_WIDTH,
  parameter int SHIFT_BITS = ACC_SHIFT_BITS,
  localparam int CW        = $clog2(ARRAY_SIZE)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       clear,
  input  logic                                       abort,
  input  logic        [SHIFT_BITS-1:0]               shift_amount,
  input  logic signed [IN_WIDTH-1:0]                 in_data,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic signed [ARRAY_SIZE-1:0][WIDE_WIDTH-1:0] wide_out,
  output logic                                       wide_valid,
  input  logic                                       wide_ready,
  output logic                                       busy,
  output logic        [CW-1:0]                       col_idx
);
  localparam logic [CW-1:0] LAST = CW'(ARRAY_SIZE-1);

  // The maximum shift must fit in the accumulator so no saturation is needed.
  if (IN_WIDTH + 2**SHIFT_BITS - 1 > WIDE_WIDTH) begin : g_width_check
    $error("tpu_accum_preload: IN_WIDTH + 2**SHIFT_BITS - 1 exceeds WIDE_WIDTH");
  end

  state_t                       state, state_nxt;
  logic [SHIFT_BITS-1:0]        shift_q;
  logic signed [WIDE_WIDTH-1:0] widened;
  logic                         take, load, zero;

  tpu_accum_widen #(
    .IN_WIDTH  (IN_WIDTH),
    .WIDE_WIDTH(WIDE_WIDTH),
    .SHIFT_BITS(SHIFT_BITS)
  ) u_widen (
    .in_data(in_data),
    .shift  (shift_q),
    .wide   (widened)
  );

  assign in_ready   = (state == FILL);
  assign wide_valid = (state == PRESENT);
  assign busy       = (state != IDLE);

  // abort masks every other action, including the write of a word in flight.
  assign take = in_ready && in_valid && !abort;
  assign load = !abort && start && ((state == IDLE) || (wide_valid && wide_ready));
  assign zero = !abort && (state == IDLE) && clear && !start;

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = FILL;
                 else if (clear) state_nxt = PRESENT;
        FILL:    if (in_valid && col_idx == LAST) state_nxt = PRESENT;
        PRESENT: if (wide_ready) state_nxt = start ? FILL : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      col_idx  <= '0;
      shift_q  <= '0;
      wide_out <= '0;
    end else begin
      state <= state_nxt;
      if (load) shift_q <= shift_amount;
      if (abort || load) col_idx <= '0;
      else if (take) col_idx <= (col_idx == LAST) ? '0 : col_idx + 1'b1;
      if (zero) wide_out <= '0;
      else if (take) wide_out[col_idx] <= widened;
    end
  end
endmodule

// File: tb/tb_tpu_accum_preload.sv
// Directed/random bench for tpu_accum_preload with ARRAY_SIZE=4; expected
// columns come from an arithmetic model (word * 2**shift) kept per column.
module tb_tpu_accum_preload;
  localparam int AS = 4;
  localparam int WW = 128;
  localparam int IW = 32;
  localparam int SB = 4;

  logic                             clk, rst_n, start, clear, abort;
  logic        [SB-1:0]             shift_amount;
  logic signed [IW-1:0]             in_data;
  logic                             in_valid, in_ready;
  logic signed [AS-1:0][WW-1:0]     wide_out;
  logic                             wide_valid, wide_ready, busy;
  logic        [1:0]                col_idx;

  tpu_accum_preload #(
    .ARRAY_SIZE(AS), .WIDE_WIDTH(WW), .IN_WIDTH(IW), .SHIFT_BITS(SB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .abort(abort),
    .shift_amount(shift_amount), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wide_out(wide_out), .wide_valid(wide_valid),
    .wide_ready(wide_ready), .busy(busy), .col_idx(col_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0]        w       [AS];
  logic signed [127:0] exp_buf [AS];

  function automatic logic signed [127:0] widen_ref(input logic [31:0] d, input int sh);
    logic signed [127:0] v;
    v = $signed(d);
    return v * (128'sd1 << sh);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag);
    for (int c = 0; c < AS; c++) chk($sformatf("%s_col%0d", tag, c), wide_out[c], exp_buf[c]);
  endtask

  task automatic zero_model();
    for (int c = 0; c < AS; c++) exp_buf[c] = '0;
  endtask

  task automatic rand_words();
    for (int i = 0; i < AS; i++) w[i] = $urandom;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wide_valid"}, wide_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_col_idx"}, col_idx, 0);
    check_vec(tag);
  endtask

  // Streams n words of w[]; shift_amount is scrambled every cycle to show
  // that only the value latched at start matters.
  task automatic stream(input int n, input int sh, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          shift_amount = 4'($urandom_range(0, 15));
          tick();
        end
      end
      shift_amount = 4'($urandom_range(0, 15));
      in_valid = 1'b1;
      in_data  = w[i];
      chk($sformatf("col_idx_%0d", i), col_idx, i);
      chk($sformatf("pre_wv_%0d", i), wide_valid, 0);
      tick();
      exp_buf[i] = widen_ref(w[i], sh);
      in_valid = 1'b0;
    end
  endtask

  task automatic start_load(input int sh);
    start = 1'b1;
    shift_amount = 4'(sh);
    tick();
    start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_col_idx", col_idx, 0);
  endtask

  task automatic full_load(input string tag, input int sh, input bit gaps);
    start_load(sh);
    stream(AS, sh, gaps);
    chk({tag, "_wide_valid"}, wide_valid, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    check_vec(tag);
  endtask

  task automatic consume(input string tag);
    wide_ready = 1'b1;
    tick();
    wide_ready = 1'b0;
    chk({tag, "_wv_after"}, wide_valid, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int sh, sh2;
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; abort = 1'b0;
    shift_amount = '0; in_data = '0; in_valid = 1'b0; wide_ready = 1'b0;
    tick(); tick();
    zero_model();
    check_reset_outs("rst");
    rst_n = 1'b1;
    tick();

    // Shift 0 with the extreme words
    w[0] = 32'd5; w[1] = 32'hFFFF_FFFF; w[2] = 32'h7FFF_FFFF; w[3] = 32'h8000_0000;
    full_load("t1", 0, 1'b0);
    chk("t1_c0_const", wide_out[0], 128'd5);
    chk("t1_c1_const", wide_out[1], {128{1'b1}});
    chk("t1_c2_const", wide_out[2], 128'h7FFF_FFFF);
    chk("t1_c3_const", wide_out[3], {{96{1'b1}}, 32'h8000_0000});
    consume("t1");

    // Shift 15
    w[0] = 32'hFFFF_FFFD; w[1] = 32'd1; w[2] = 32'd2; w[3] = 32'd3;
    full_load("t2", 15, 1'b0);
    chk("t2_c0_const", wide_out[0], -128'sd98304);
    chk("t2_c1_const", wide_out[1], 128'd32768);
    chk("t2_c2_const", wide_out[2], 128'd65536);
    chk("t2_c3_const", wide_out[3], 128'd98304);
    consume("t2");

    // Gaps, backpressure hold, then handoff straight into the next load
    rand_words();
    sh = $urandom_range(0, 15);
    full_load("t3", sh, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t3_hold_wv_%0d", k), wide_valid, 1);
      check_vec($sformatf("t3_hold_%0d", k));
    end
    sh2 = $urandom_range(0, 15);
    start = 1'b1; wide_ready = 1'b1; shift_amount = 4'(sh2);
    tick();
    start = 1'b0; wide_ready = 1'b0;
    chk("t3_b2b_in_ready", in_ready, 1);
    chk("t3_b2b_col_idx", col_idx, 0);
    chk("t3_b2b_wv", wide_valid, 0);
    rand_words();
    stream(AS, sh2, 1'b1);
    chk("t3b_wide_valid", wide_valid, 1);
    check_vec("t3b");
    consume("t3b");

    // clear, then start+clear together
    clear = 1'b1;
    tick();
    clear = 1'b0;
    zero_model();
    chk("t4_clear_wv", wide_valid, 1);
    check_vec("t4_clear");
    consume("t4");
    sh = $urandom_range(0, 15);
    start = 1'b1; clear = 1'b1; shift_amount = 4'(sh);
    tick();
    start = 1'b0; clear = 1'b0;
    chk("t4_sc_in_ready", in_ready, 1);
    chk("t4_sc_wv", wide_valid, 0);
    rand_words();
    stream(AS, sh, 1'b0);
    chk("t4_sc_done_wv", wide_valid, 1);
    check_vec("t4_sc");
    consume("t4_sc");

    // abort after two words; a word offered with abort must not land
    rand_words();
    sh = $urandom_range(0, 15);
    start_load(sh);
    stream(2, sh, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_data = $urandom;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_col_idx", col_idx, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_wv", wide_valid, 0);
    repeat (2) begin
      tick();
      chk("t5_idle_wv", wide_valid, 0);
    end
    check_vec("t5_retained");
    rand_words();
    full_load("t5_new", $urandom_range(0, 15), 1'b1);
    consume("t5_new");

    // Reset in FILL after three words
    rand_words();
    sh = $urandom_range(0, 15);
    start_load(sh);
    stream(3, sh, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    zero_model();
    check_reset_outs("t6_fill");
    tick();

    // Reset in PRESENT
    rand_words();
    full_load("t6_pre", $urandom_range(0, 15), 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    zero_model();
    check_reset_outs("t6_present");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
